// File: rtl/d5m_gen_pkg.sv
// d5m_gen_pkg: shared state encoding, pattern codes, Bayer phases and LFSR constants
// for the synthetic D5M stream generator.
package d5m_gen_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FRONT,
        ST_ACTIVE,
        ST_HBLANK,
        ST_TAIL,
        ST_VBLANK
    } state_t;

    localparam logic [1:0] PAT_RAMP  = 2'd0;
    localparam logic [1:0] PAT_BARS  = 2'd1;
    localparam logic [1:0] PAT_CHECK = 2'd2;
    localparam logic [1:0] PAT_TAG   = 2'd3;

    // Bayer phase indexed by {Y[0], X[0]}
    localparam logic [1:0] PH_G_EVEN = 2'b00;
    localparam logic [1:0] PH_R      = 2'b01;
    localparam logic [1:0] PH_B      = 2'b10;
    localparam logic [1:0] PH_G_ODD  = 2'b11;

    // x^16+x^14+x^13+x^11+1 in right-shift Fibonacci form: feedback from bits 0,2,3,5
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {^(l & LFSR_TAPS), l[15:1]};
    endfunction

endpackage

// File: rtl/d5m_pattern_lut.sv
// d5m_pattern_lut: combinational pixel value for the selected test pattern
// at column x and line y; tag_i carries the frame tag or LFSR noise.
module d5m_pattern_lut
    import d5m_gen_pkg::*;
#(
    parameter int H_ACTIVE = 1280
) (
    input  logic [1:0]  pattern_i,
    input  logic [15:0] x_i,
    input  logic        y0_i,
    input  logic        y4_i,
    input  logic [11:0] tag_i,
    output logic [11:0] pix_o
);

    logic [2:0] bar;
    logic [1:0] phase;
    logic       on;

    assign bar   = 3'(x_i / 16'(H_ACTIVE / 8));
    assign phase = {y0_i, x_i[0]};

    always_comb begin
        on    = phase == PH_R ? bar[2] : phase == PH_B ? bar[0] : bar[1];
        pix_o = pattern_i == PAT_RAMP  ? x_i[11:0] :
                pattern_i == PAT_BARS  ? {12{on}} :
                pattern_i == PAT_CHECK ? {12{x_i[4] ^ y4_i}} : tag_i;
    end

endmodule

// File: rtl/d5m_stream_gen.sv
// d5m_stream_gen: D5M sensor emulator driving FVAL/LVAL/12-bit Bayer test patterns.
// Define D5M_GEN_LFSR_EN to turn pattern 3 into per-frame repeatable LFSR noise.
module d5m_stream_gen
    import d5m_gen_pkg::*;
#(
    parameter int H_ACTIVE = 1280,
    parameter int V_ACTIVE = 960,
    parameter int H_BLANK  = 32,
    parameter int V_BLANK  = 64,
    parameter int FV_TO_LV = 4,
    parameter int LV_TO_FV = 4
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iSTART,
    input  logic        iEND,
    input  logic [1:0]  iPATTERN,
    output logic [11:0] oDATA,
    output logic        oFVAL,
    output logic        oLVAL,
    output logic [15:0] oX_Cont,
    output logic [15:0] oY_Cont,
    output logic [31:0] oFrame_Cont,
    output logic        oBUSY
);

    state_t      state_q;
    logic        run_q, run_d;
    logic [15:0] cnt_q, x_q, y_q, nx;
    logic [31:0] frame_q;
    logic [1:0]  pat_q;
    logic [11:0] data_q, pix, tag;
    logic        fval_q, lval_q, busy_q;

    // iEND beats iSTART; the FSM only looks at this in IDLE and at the end of VBLANK
    assign run_d = iEND ? 1'b0 : (iSTART | run_q);
    // column of the pixel about to be loaded into data_q
    assign nx    = state_q == ST_ACTIVE ? x_q + 16'd1 : 16'd0;

`ifdef D5M_GEN_LFSR_EN
    logic [15:0] lfsr_q;
    logic        fv_rise, lv_load;

    assign fv_rise = run_d && (state_q == ST_IDLE ||
                     (state_q == ST_VBLANK && cnt_q == 16'(V_BLANK - 1)));
    assign lv_load = (state_q == ST_ACTIVE && x_q != 16'(H_ACTIVE - 1)) ||
                     (state_q == ST_FRONT && cnt_q == 16'(FV_TO_LV - 1)) ||
                     (state_q == ST_HBLANK && cnt_q == 16'(H_BLANK - 1));
    assign tag     = lfsr_q[11:0];

    always_ff @(posedge iCLK or posedge iRST)
        if (iRST)
            lfsr_q <= LFSR_SEED;
        else if (fv_rise)
            lfsr_q <= LFSR_SEED;
        else if (lv_load)
            lfsr_q <= lfsr_next(lfsr_q);
`else
    assign tag = frame_q[11:0];
`endif

    d5m_pattern_lut #(.H_ACTIVE(H_ACTIVE)) u_lut (
        .pattern_i (pat_q),
        .x_i       (nx),
        .y0_i      (y_q[0]),
        .y4_i      (y_q[4]),
        .tag_i     (tag),
        .pix_o     (pix)
    );

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q <= ST_IDLE;
            run_q   <= 1'b0;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            frame_q <= '0;
            pat_q   <= PAT_RAMP;
            data_q  <= '0;
            fval_q  <= 1'b0;
            lval_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            run_q <= run_d;
            case (state_q)
                ST_IDLE:
                    if (run_d) begin
                        state_q <= ST_FRONT;
                        fval_q  <= 1'b1;
                        busy_q  <= 1'b1;
                        pat_q   <= iPATTERN;
                        cnt_q   <= '0;
                    end
                ST_FRONT:
                    if (cnt_q == 16'(FV_TO_LV - 1)) begin
                        state_q <= ST_ACTIVE;
                        lval_q  <= 1'b1;
                        data_q  <= pix;
                        x_q     <= '0;
                    end else
                        cnt_q <= cnt_q + 16'd1;
                ST_ACTIVE:
                    if (x_q == 16'(H_ACTIVE - 1)) begin
                        lval_q  <= 1'b0;
                        data_q  <= '0;
                        x_q     <= '0;
                        cnt_q   <= '0;
                        state_q <= y_q == 16'(V_ACTIVE - 1) ? ST_TAIL : ST_HBLANK;
                        y_q     <= y_q == 16'(V_ACTIVE - 1) ? y_q : y_q + 16'd1;
                    end else begin
                        x_q    <= nx;
                        data_q <= pix;
                    end
                ST_HBLANK:
                    if (cnt_q == 16'(H_BLANK - 1)) begin
                        state_q <= ST_ACTIVE;
                        lval_q  <= 1'b1;
                        data_q  <= pix;
                    end else
                        cnt_q <= cnt_q + 16'd1;
                ST_TAIL:
                    if (cnt_q == 16'(LV_TO_FV - 1)) begin
                        state_q <= ST_VBLANK;
                        fval_q  <= 1'b0;
                        frame_q <= frame_q + 32'd1;
                        y_q     <= '0;
                        cnt_q   <= '0;
                    end else
                        cnt_q <= cnt_q + 16'd1;
                ST_VBLANK:
                    if (cnt_q == 16'(V_BLANK - 1)) begin
                        state_q <= run_d ? ST_FRONT : ST_IDLE;
                        fval_q  <= run_d;
                        busy_q  <= run_d;
                        pat_q   <= run_d ? iPATTERN : pat_q;
                        cnt_q   <= '0;
                    end else
                        cnt_q <= cnt_q + 16'd1;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign oDATA       = data_q;
    assign oFVAL       = fval_q;
    assign oLVAL       = lval_q;
    assign oX_Cont     = x_q;
    assign oY_Cont     = y_q;
    assign oFrame_Cont = frame_q;
    assign oBUSY       = busy_q;

endmodule

// File: tb/tb_d5m_stream_gen.sv
// tb_d5m_stream_gen: randomized-pattern bench comparing the stream against a
// frame-timing model built from plain per-cycle arithmetic.
module tb_d5m_stream_gen;

    localparam int H   = 8;
    localparam int V   = 4;
    localparam int HB  = 3;
    localparam int VB  = 5;
    localparam int F2L = 2;
    localparam int L2F = 2;
    localparam int ACT_LEN = V * H + (V - 1) * HB;
    localparam int FV_LEN  = F2L + ACT_LEN + L2F;
    localparam int PERIOD  = FV_LEN + VB;
    localparam int LINE2_T = F2L + 2 * (H + HB) + 3;

    logic        clk = 1'b0;
    logic        iRST, iSTART, iEND;
    logic [1:0]  iPATTERN;
    logic [11:0] oDATA;
    logic        oFVAL, oLVAL, oBUSY;
    logic [15:0] oX_Cont, oY_Cont;
    logic [31:0] oFrame_Cont;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    d5m_stream_gen #(
        .H_ACTIVE(H), .V_ACTIVE(V), .H_BLANK(HB),
        .V_BLANK(VB), .FV_TO_LV(F2L), .LV_TO_FV(L2F)
    ) dut (
        .iCLK(clk), .iRST(iRST), .iSTART(iSTART), .iEND(iEND), .iPATTERN(iPATTERN),
        .oDATA(oDATA), .oFVAL(oFVAL), .oLVAL(oLVAL), .oX_Cont(oX_Cont),
        .oY_Cont(oY_Cont), .oFrame_Cont(oFrame_Cont), .oBUSY(oBUSY)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
    endfunction

    function automatic logic [11:0] exp_pix(input logic [1:0] pat, input int col, input int line,
                                            input int fidx, input logic [15:0] lf);
        int bar, comp;
        bar  = col / (H / 8);
        // component bit within bar: B=0, G=1, R=2
        comp = (line % 2 == 1 && col % 2 == 0) ? 0 : (line % 2 == 0 && col % 2 == 1) ? 2 : 1;
        case (pat)
            2'd0: return 12'(col);
            2'd1: return ((bar >> comp) & 1) != 0 ? 12'hFFF : 12'h000;
            2'd2: return (((col >> 4) ^ (line >> 4)) & 1) != 0 ? 12'hFFF : 12'h000;
            default:
`ifdef D5M_GEN_LFSR_EN
                return lf[11:0];
`else
                return 12'(fidx);
`endif
        endcase
    endfunction

    function automatic logic [63:0] outs();
        return {17'd0, oBUSY, oFVAL, oLVAL, oDATA, oX_Cont, oY_Cont};
    endfunction

    task automatic start(input logic [1:0] pat);
        iPATTERN = pat;
        iSTART   = 1'b1;
        @(negedge clk);
        iSTART   = 1'b0;
    endtask

    // Checks one full frame period starting at the first cycle with FVAL high.
    task automatic run_frame(input logic [1:0] pat, input int fidx, input logic [1:0] next_pat,
                             input bit stop);
        logic [15:0] lf;
        logic [11:0] ed;
        int u, line, col, ex, ey;
        bit fv, lv;
        lf = 16'hACE1;
        for (int t = 0; t < PERIOD; t++) begin
            fv = t < FV_LEN;
            lv = 1'b0;
            ex = 0;
            ey = 0;
            ed = '0;
            u  = t - F2L;
            if (t >= F2L && u < ACT_LEN) begin
                line = u / (H + HB);
                col  = u % (H + HB);
                if (col < H) begin
                    lv = 1'b1;
                    ex = col;
                    ey = line;
                    ed = exp_pix(pat, col, line, fidx, lf);
                    lf = lfsr_step(lf);
                end else
                    ey = line + 1;
            end else if (fv && t >= F2L)
                ey = V - 1;
            check($sformatf("f%0d_p%0d_t%0d", fidx, pat, t), outs(),
                  {17'd0, 1'b1, fv, lv, ed, 16'(ex), 16'(ey)});
            if (t == 0 || t == PERIOD - 1)
                check($sformatf("frame_cnt_f%0d_t%0d", fidx, t), {32'd0, oFrame_Cont},
                      64'(fv ? fidx : fidx + 1));
            if (t == 10) iPATTERN = 2'($urandom);
            if (t == 20) iPATTERN = next_pat;
            iEND = stop && t == LINE2_T;
            @(negedge clk);
        end
        iEND = 1'b0;
    endtask

    logic [1:0] seq [7];

    initial begin
        iRST = 1'b1;
        iSTART = 1'b0;
        iEND = 1'b0;
        iPATTERN = 2'd0;
        repeat (3) @(negedge clk);
        check("reset_outs", outs(), 64'd0);
        check("reset_frame", {32'd0, oFrame_Cont}, 64'd0);
        iRST = 1'b0;
        @(negedge clk);
        check("idle_outs", outs(), 64'd0);

        seq[0] = 2'd0;
        seq[1] = 2'd2;
        seq[2] = 2'd1;
        seq[3] = 2'd3;
        for (int i = 4; i < 7; i++) seq[i] = 2'($urandom);
        start(seq[0]);
        for (int f = 0; f < 7; f++)
            run_frame(seq[f], f, f < 6 ? seq[f + 1] : seq[f], f == 6);
        check("stopped_outs", outs(), 64'd0);
        check("stopped_frame", {32'd0, oFrame_Cont}, 64'd7);

        iSTART = 1'b1;
        iEND   = 1'b1;
        @(negedge clk);
        iSTART = 1'b0;
        iEND   = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check($sformatf("start_end_idle_%0d", i), {62'd0, oBUSY, oFVAL}, 64'd0);
            @(negedge clk);
        end

        start(2'd0);
        repeat (15) @(negedge clk);
        check("pre_reset_lval", {63'd0, oLVAL}, 64'd1);
        #2 iRST = 1'b1;
        #1;
        check("async_reset_outs", outs(), 64'd0);
        check("async_reset_frame", {32'd0, oFrame_Cont}, 64'd0);
        @(negedge clk);
        iRST = 1'b0;
        @(negedge clk);

        start(2'd3);
        run_frame(2'd3, 0, 2'd3, 1'b1);
        check("end_frame_cnt", {32'd0, oFrame_Cont}, 64'd1);
        check("end_idle_outs", outs(), 64'd0);
        repeat (3) @(negedge clk);
        check("end_still_idle", {62'd0, oBUSY, oFVAL}, 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
